// File: rtl/cmac_ctrl.sv
// cmac_ctrl: sequencer that streams operand pairs from the data/weight buffers into cmac,
// hands each accumulated result downstream and clears the accumulator between outputs.
// Ports: clk/rst (async active-high); start + cfg_* job setup; busy/done status;
// d_rd_*/w_rd_* operand buffer reads (1-cycle latency); mac_* cmac interface;
// res_data/res_idx/res_valid/res_ready result handshake.
module cmac_ctrl #(
   parameter int ADDR_W = 10,
   parameter int KLEN_W = 8,
   parameter int OCNT_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KLEN_W-1:0] cfg_klen,
   input  logic [OCNT_W-1:0] cfg_ocnt,
   input  logic [ADDR_W-1:0] cfg_d_base,
   input  logic [ADDR_W-1:0] cfg_d_stride,
   input  logic [ADDR_W-1:0] cfg_w_base,
   output logic              busy,
   output logic              done,
   output logic              d_rd_en,
   output logic [ADDR_W-1:0] d_rd_addr,
   input  logic [15:0]       d_rd_data,
   output logic              w_rd_en,
   output logic [ADDR_W-1:0] w_rd_addr,
   input  logic [15:0]       w_rd_data,
   output logic [15:0]       mac_data,
   output logic [15:0]       mac_weight,
   output logic              mac_data_ready,
   input  logic              mac_data_valid,
   output logic              mac_conv_valid,
   input  logic              mac_conv_ready,
   output logic              mac_rst_acc,
   input  logic [15:0]       mac_result,
   output logic [15:0]       res_data,
   output logic [OCNT_W-1:0] res_idx,
   output logic              res_valid,
   input  logic              res_ready
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FEED, S_WAIT_RES, S_WRITE, S_CLEAR, S_DONE} state_t;
   state_t r_state, w_next;
   logic [KLEN_W-1:0] r_k, r_klen, w_k_inc;
   logic [OCNT_W-1:0] r_o, r_ocnt, w_o_inc, r_res_idx;
   // r_row tracks d_base + o*d_stride incrementally, avoiding a multiplier
   logic [ADDR_W-1:0] r_row, r_stride, r_w_base;
   logic [15:0]       r_mac_data, r_mac_weight, r_res_data;
   logic              w_feed, w_fetch;
   assign w_k_inc        = r_k + 1'b1;
   assign w_o_inc        = r_o + 1'b1;
   assign w_feed         = r_state == S_FEED;
   assign w_fetch        = r_state == S_FETCH && mac_data_valid;
   assign busy           = r_state != S_IDLE && r_state != S_DONE;
   assign mac_conv_valid = busy;
   assign done           = r_state == S_DONE;
   assign mac_rst_acc    = r_state == S_CLEAR;
   assign res_valid      = r_state == S_WRITE;
   assign mac_data_ready = w_feed;
   assign d_rd_en        = w_fetch;
   assign w_rd_en        = w_fetch;
   assign d_rd_addr      = r_row + ADDR_W'(r_k);
   assign w_rd_addr      = r_w_base + ADDR_W'(r_k);
   // buffer data is live only in FEED; the registered copy holds it afterwards
   assign mac_data       = w_feed ? d_rd_data : r_mac_data;
   assign mac_weight     = w_feed ? w_rd_data : r_mac_weight;
   assign res_data       = r_res_data;
   assign res_idx        = r_res_idx;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     w_next = !start ? S_IDLE : (cfg_klen == '0 || cfg_ocnt == '0) ? S_DONE : S_FETCH;
         S_FETCH:    w_next = mac_data_valid ? S_FEED : S_FETCH;
         S_FEED:     w_next = (w_k_inc == r_klen) ? S_WAIT_RES : S_FETCH;
         S_WAIT_RES: w_next = mac_conv_ready ? S_WRITE : S_WAIT_RES;
         S_WRITE:    w_next = res_ready ? S_CLEAR : S_WRITE;
         S_CLEAR:    w_next = (w_o_inc == r_ocnt) ? S_DONE : S_FETCH;
         default:    w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_k          <= '0;
         r_klen       <= '0;
         r_o          <= '0;
         r_ocnt       <= '0;
         r_row        <= '0;
         r_stride     <= '0;
         r_w_base     <= '0;
         r_mac_data   <= '0;
         r_mac_weight <= '0;
         r_res_data   <= '0;
         r_res_idx    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && start) begin
            r_klen   <= cfg_klen;
            r_ocnt   <= cfg_ocnt;
            r_row    <= cfg_d_base;
            r_stride <= cfg_d_stride;
            r_w_base <= cfg_w_base;
            r_k      <= '0;
            r_o      <= '0;
         end
         if (w_feed) begin
            r_k          <= w_k_inc;
            r_mac_data   <= d_rd_data;
            r_mac_weight <= w_rd_data;
         end
         if (r_state == S_WAIT_RES && mac_conv_ready) begin
            r_res_data <= mac_result;
            r_res_idx  <= r_o;
         end
         if (r_state == S_CLEAR) begin
            r_k   <= '0;
            r_o   <= w_o_inc;
            r_row <= r_row + r_stride;
         end
      end
   end
endmodule

// File: tb/tb_cmac_ctrl.sv
// tb_cmac_ctrl: directed self-checking bench for cmac_ctrl with behavioural operand buffers.
module tb_cmac_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  cfg_klen = '0;
   logic [11:0] cfg_ocnt = '0;
   logic [9:0]  cfg_d_base = '0, cfg_d_stride = '0, cfg_w_base = '0;
   logic        busy, done, d_rd_en, w_rd_en, mac_data_ready, mac_conv_valid, mac_rst_acc, res_valid;
   logic [9:0]  d_rd_addr, w_rd_addr;
   logic [15:0] d_rd_data = '0, w_rd_data = '0, mac_data, mac_weight, res_data;
   logic        mac_data_valid = 1'b1, mac_conv_ready = 1'b1, res_ready = 1'b1;
   logic [15:0] mac_result = '0;
   logic [11:0] res_idx;
   logic [15:0] dmem [1024];
   logic [15:0] wmem [1024];
   logic [9:0]  d_q [$];
   logic [9:0]  w_q [$];
   logic [31:0] pair_q [$];
   logic [11:0] ri_q [$];
   logic [15:0] rd_q [$];
   int n_cmp = 0, n_err = 0;
   int n_rdy, n_rst, n_done, n_cv, n_stall_rd, t_start, t_rd, t_done;
   int cyc = 0;
   logic tgl = 1'b0;
   logic [9:0] exp_d [6];
   logic [9:0] exp_w [6];

   cmac_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_klen(cfg_klen), .cfg_ocnt(cfg_ocnt), .cfg_d_base(cfg_d_base),
      .cfg_d_stride(cfg_d_stride), .cfg_w_base(cfg_w_base),
      .busy(busy), .done(done),
      .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr), .d_rd_data(d_rd_data),
      .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
      .mac_data(mac_data), .mac_weight(mac_weight), .mac_data_ready(mac_data_ready),
      .mac_data_valid(mac_data_valid), .mac_conv_valid(mac_conv_valid),
      .mac_conv_ready(mac_conv_ready), .mac_rst_acc(mac_rst_acc), .mac_result(mac_result),
      .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // single-port buffers with one cycle of read latency
   always @(posedge clk) begin
      if (d_rd_en) d_rd_data <= dmem[d_rd_addr];
      if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
   end

   always @(negedge clk) begin
      if (d_rd_en) begin
         d_q.push_back(d_rd_addr);
         if (!mac_data_valid) n_stall_rd <= n_stall_rd + 1;
         if (t_rd < 0) t_rd <= cyc;
      end
      if (w_rd_en) w_q.push_back(w_rd_addr);
      if (mac_data_ready) begin
         n_rdy <= n_rdy + 1;
         pair_q.push_back({mac_data, mac_weight});
      end
      if (mac_rst_acc) n_rst <= n_rst + 1;
      if (mac_conv_valid) n_cv <= n_cv + 1;
      if (res_valid && res_ready) begin
         ri_q.push_back(res_idx);
         rd_q.push_back(res_data);
      end
      if (done) begin
         n_done <= n_done + 1;
         if (t_done < 0) t_done <= cyc;
      end
      if (start && t_start < 0) t_start <= cyc;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      d_q.delete(); w_q.delete(); pair_q.delete(); ri_q.delete(); rd_q.delete();
      n_rdy = 0; n_rst = 0; n_done = 0; n_cv = 0; n_stall_rd = 0;
      t_start = -1; t_rd = -1; t_done = -1;
   endtask

   task automatic set_cfg(input int k, input int o, input int db, input int ds, input int wb);
      cfg_klen = 8'(k); cfg_ocnt = 12'(o);
      cfg_d_base = 10'(db); cfg_d_stride = 10'(ds); cfg_w_base = 10'(wb);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && n_done == 0; i++) begin
         @(posedge clk); #1;
         if (tgl) mac_data_valid = !mac_data_valid;
      end
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, "_ctl"}, {24'd0, busy, done, d_rd_en, w_rd_en, mac_data_ready,
             mac_conv_valid, mac_rst_acc, res_valid}, 32'd0);
      check({tag, "_addr"}, {12'd0, d_rd_addr, w_rd_addr}, 32'd0);
      check({tag, "_mac"}, {mac_data, mac_weight}, 32'd0);
      check({tag, "_res"}, {4'd0, res_data, res_idx}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin dmem[i] = 16'(i * 3 + 1); wmem[i] = 16'(16'h8000 + i); end
      clear_mon();
      repeat (3) @(negedge clk);
      check_idle_outs("reset_hold");
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check_idle_outs("reset_release");
      @(posedge clk); #1;

      // single output, klen=3
      dmem[0] = 16'h3c00; dmem[1] = 16'h4000; dmem[2] = 16'h4200;
      wmem[0] = 16'h3c00; wmem[1] = 16'h4000; wmem[2] = 16'h4200;
      mac_result = 16'h4B00;
      clear_mon(); set_cfg(3, 1, 0, 0, 0);
      pulse_start(); wait_done(100);
      check("t1_done", n_done, 1);
      check("t1_nrd", d_q.size(), 3);
      for (int i = 0; i < 3; i++) check($sformatf("t1_daddr%0d", i), d_q[i], i);
      for (int i = 0; i < 3; i++) check($sformatf("t1_waddr%0d", i), w_q[i], i);
      check("t1_nrdy", n_rdy, 3);
      check("t1_pair0", pair_q[0], 32'h3c003c00);
      check("t1_pair1", pair_q[1], 32'h40004000);
      check("t1_pair2", pair_q[2], 32'h42004200);
      check("t1_nres", ri_q.size(), 1);
      check("t1_rdata", rd_q[0], 16'h4B00);
      check("t1_ridx", ri_q[0], 0);
      check("t1_nrst", n_rst, 1);

      // latency, klen=1 ocnt=1
      clear_mon(); set_cfg(1, 1, 0, 0, 0);
      pulse_start(); wait_done(100);
      check("lat_rd", t_rd - t_start, 1);
      check("lat_done", t_done - t_start, 6);

      // multi-output with stride
      dmem[0] = 16'h1000; dmem[1] = 16'h1001; wmem[16] = 16'h5555; wmem[17] = 16'h6666;
      mac_result = 16'h4400;
      exp_d = '{10'd0, 10'd1, 10'd4, 10'd5, 10'd8, 10'd9};
      exp_w = '{10'd16, 10'd17, 10'd16, 10'd17, 10'd16, 10'd17};
      clear_mon(); set_cfg(2, 3, 0, 4, 16);
      pulse_start(); wait_done(200);
      check("t2_done", n_done, 1);
      check("t2_nrd", d_q.size(), 6);
      for (int i = 0; i < 6; i++) check($sformatf("t2_daddr%0d", i), d_q[i], exp_d[i]);
      for (int i = 0; i < 6; i++) check($sformatf("t2_waddr%0d", i), w_q[i], exp_w[i]);
      check("t2_pair0", pair_q[0], 32'h10005555);
      check("t2_pair1", pair_q[1], 32'h10016666);
      check("t2_nres", ri_q.size(), 3);
      for (int i = 0; i < 3; i++) check($sformatf("t2_ridx%0d", i), ri_q[i], i);
      check("t2_nrst", n_rst, 3);
      check("t2_nrdy", n_rdy, 6);

      // result backpressure
      mac_result = 16'h3555; res_ready = 1'b0;
      clear_mon(); set_cfg(1, 2, 0, 1, 0);
      pulse_start();
      for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
      check("t3_valid_seen", res_valid, 1);
      mac_result = 16'h1111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("t3_hold%0d", i), {3'd0, res_valid, res_data, res_idx}, {4'h1, 16'h3555, 12'd0});
         check($sformatf("t3_nord%0d", i), d_q.size(), 1);
         check($sformatf("t3_norst%0d", i), n_rst, 0);
      end
      @(posedge clk); #1; res_ready = 1'b1;
      wait_done(100);
      check("t3_done", n_done, 1);
      check("t3_nres", rd_q.size(), 2);
      check("t3_rdata0", rd_q[0], 16'h3555);
      check("t3_rdata1", rd_q[1], 16'h1111);
      check("t3_ridx1", ri_q[1], 1);

      // operand stall and address wrap
      clear_mon(); set_cfg(4, 1, 10'h3FE, 0, 0);
      pulse_start();
      tgl = 1'b1;
      wait_done(200);
      tgl = 1'b0; mac_data_valid = 1'b1;
      check("t4_done", n_done, 1);
      check("t4_stall_rd", n_stall_rd, 0);
      check("t4_nrd", d_q.size(), 4);
      check("t4_daddr0", d_q[0], 10'h3FE);
      check("t4_daddr1", d_q[1], 10'h3FF);
      check("t4_daddr2", d_q[2], 10'h000);
      check("t4_daddr3", d_q[3], 10'h001);
      check("t4_nrdy", n_rdy, 4);

      // degenerate klen=0
      clear_mon(); set_cfg(0, 5, 0, 0, 0);
      pulse_start(); wait_done(20);
      check("t5_done", n_done, 1);
      check("t5_within2", (t_done >= 0 && t_done - t_start <= 2) ? 1 : 0, 1);
      check("t5_nrd", d_q.size() + w_q.size(), 0);
      check("t5_nrdy", n_rdy, 0);
      check("t5_ncv", n_cv, 0);

      // second start while busy is ignored
      clear_mon(); set_cfg(1, 1, 0, 0, 0);
      pulse_start();
      @(posedge clk); #1;
      pulse_start();
      wait_done(100);
      repeat (12) @(posedge clk); #1;
      check("t5_jobs", n_done, 1);
      check("t5_nres", ri_q.size(), 1);

      // asynchronous reset during FEED of output 1
      clear_mon(); set_cfg(2, 3, 0, 4, 16);
      pulse_start();
      for (int i = 0; i < 100 && !(mac_data_ready && ri_q.size() == 1); i++) @(negedge clk);
      check("t6_feed1", {31'd0, mac_data_ready}, 1);
      rst = 1'b1;
      #1;
      check_idle_outs("t6_async");
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      clear_mon(); set_cfg(2, 3, 0, 4, 16);
      pulse_start(); wait_done(200);
      check("t6_done", n_done, 1);
      check("t6_nrd", d_q.size(), 6);
      for (int i = 0; i < 6; i++) check($sformatf("t6_daddr%0d", i), d_q[i], exp_d[i]);
      check("t6_nres", ri_q.size(), 3);
      for (int i = 0; i < 3; i++) check($sformatf("t6_ridx%0d", i), ri_q[i], i);
      check("t6_nrst", n_rst, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
